// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master arbiter for the shared data/IO memory bus. Port 0 is the CPU MEM stage, port 1 is
//   the DMA/debug loader. Ties are broken round-robin. A master may hold a bounded lock to get
//   back-to-back grants for a burst. Each read is sequenced through a fixed downstream read
//   latency, and the registered read data is returned to the master that issued it.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req[1:0]          per-master request level, held until gnt is seen
//   lock[1:0]         per-master burst lock, sampled together with req
//   addr/ctrl/wd      per-master address, ctrl {unsigned, type[1:0], we}, write data;
//                     master k uses slice [k*W +: W]
//   gnt[1:0]          one-cycle pulse in the transfer cycle of master k's request
//   rvalid[1:0]       one-cycle pulse when rdata holds master k's read data
//   rdata             shared read data, qualified by rvalid, held until the next capture
//   busy              high while a transfer is in progress
//   mem_addr/mem_ctrl/mem_wd/mem_we   registered downstream request
//   mem_rd            downstream read data, valid RD_LAT cycles after the address cycle

module mem_bus_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned CW        = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned RD_LAT    = 1,   // legal 1..7
    parameter int unsigned MAX_BURST = 4    // legal 1..15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [1:0]      lock,
    input  logic [2*AW-1:0] addr,
    input  logic [2*CW-1:0] ctrl,
    input  logic [2*DW-1:0] wd,
    output logic [1:0]      gnt,
    output logic [1:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic [AW-1:0]   mem_addr,
    output logic [CW-1:0]   mem_ctrl,
    output logic [DW-1:0]   mem_wd,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_rd
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StWait
    } state_e;

    localparam logic [3:0] BurstLim = 4'(MAX_BURST - 1);
    localparam logic [2:0] RdLat    = 3'(RD_LAT);

    state_e          state_q, state_d;
    // own_q is both the last round-robin winner and the current lock owner.
    logic            own_q, own_d;
    logic [3:0]      burst_q, burst_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0]   mem_ctrl_q, mem_ctrl_d;
    logic [DW-1:0]   mem_wd_q, mem_wd_d;
    logic            mem_we_q, mem_we_d;

    // Arbitration result
    logic            lock_hit;
    logic            win_valid;
    logic            win;
    logic [AW-1:0]   sel_addr;
    logic [CW-1:0]   sel_ctrl;
    logic [DW-1:0]   sel_wd;

    // Lock only extends the current owner's tenure while it still asks for the bus and has
    // grants left in its burst budget; otherwise fall back to normal arbitration.
    assign lock_hit = req[own_q] & lock[own_q] & (burst_q < BurstLim);

    always_comb begin
        win_valid = 1'b0;
        win       = own_q;
        if (lock_hit) begin
            win_valid = 1'b1;
            win       = own_q;
        end else if (req == 2'b01) begin
            win_valid = 1'b1;
            win       = 1'b0;
        end else if (req == 2'b10) begin
            win_valid = 1'b1;
            win       = 1'b1;
        end else if (req == 2'b11) begin
            win_valid = 1'b1;
            win       = ~own_q;
        end
    end

    assign sel_addr = win ? addr[2*AW-1:AW] : addr[AW-1:0];
    assign sel_ctrl = win ? ctrl[2*CW-1:CW] : ctrl[CW-1:0];
    assign sel_wd   = win ? wd[2*DW-1:DW]   : wd[DW-1:0];

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        // Downstream bus is idle (all zero) unless a state below drives it.
        mem_addr_d = '0;
        mem_ctrl_d = '0;
        mem_wd_d   = '0;
        mem_we_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d    = StGrant;
                    gnt_d      = win ? 2'b10 : 2'b01;
                    mem_addr_d = sel_addr;
                    mem_ctrl_d = sel_ctrl;
                    mem_wd_d   = sel_wd;
                    mem_we_d   = sel_ctrl[0];
                    if (lock_hit) begin
                        burst_d = burst_q + 4'd1;
                    end else begin
                        burst_d = 4'd0;
                        own_d   = win;
                    end
                end
            end

            StGrant: begin
                // mem_we_q is the registered write flag of the transfer now on the bus.
                if (mem_we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d    = StWait;
                    cnt_d      = 3'd1;
                    mem_addr_d = mem_addr_q;
                    mem_ctrl_d = mem_ctrl_q;
                end
            end

            StWait: begin
                if (cnt_q == RdLat) begin
                    state_d  = StIdle;
                    rdata_d  = mem_rd;
                    rvalid_d = own_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_addr_d = mem_addr_q;
                    mem_ctrl_d = mem_ctrl_q;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            own_q      <= 1'b1;   // port 0 wins the first tie
            burst_q    <= 4'd0;
            cnt_q      <= 3'd0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_ctrl_q <= '0;
            mem_wd_q   <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_wd_q   <= mem_wd_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != StIdle);
    assign mem_addr = mem_addr_q;
    assign mem_ctrl = mem_ctrl_q;
    assign mem_wd   = mem_wd_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios with fixed expected values, followed by randomized traffic compared
//   against a timeline model of the arbiter (grant decisions and scheduled bus activity).

module tb_mem_bus_arbiter;

    localparam int AW        = 32;
    localparam int CW        = 4;
    localparam int DW        = 32;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int NCYC      = 1500;
    localparam int NC        = NCYC + 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req = '0;
    logic [1:0]      lock = '0;
    logic [2*AW-1:0] addr = '0;
    logic [2*CW-1:0] ctrl = '0;
    logic [2*DW-1:0] wd = '0;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [CW-1:0]   mem_ctrl;
    logic [DW-1:0]   mem_wd;
    logic            mem_we;
    logic [DW-1:0]   mem_rd = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model storage: expected outputs per cycle of the random run.
    logic [1:0]    e_gnt  [NC];
    logic [1:0]    e_rv   [NC];
    logic [AW-1:0] e_addr [NC];
    logic [CW-1:0] e_ctrl [NC];
    logic [DW-1:0] e_wd   [NC];
    logic          e_we   [NC];
    logic          e_busy [NC];
    logic [DW-1:0] mrd_hist [NC];

    mem_bus_arbiter #(
        .AW        (AW),
        .CW        (CW),
        .DW        (DW),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .addr     (addr),
        .ctrl     (ctrl),
        .wd       (wd),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_ctrl (mem_ctrl),
        .mem_wd   (mem_wd),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = '0;
        lock   = '0;
        addr   = '0;
        ctrl   = '0;
        wd     = '0;
        mem_rd = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({gnt, rvalid, busy, mem_we} !== 6'b0 || mem_addr !== '0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: gnt=%b rvalid=%b busy=%b we=%b addr=%h rdata=%h, want all 0",
                     gnt, rvalid, busy, mem_we, mem_addr, rdata);
        end
        // Port 1 read, then reset asserted in the middle of WAIT.
        req = 2'b10;
        addr[2*AW-1:AW] = 32'h80;
        ctrl[2*CW-1:CW] = 4'b0000;
        tick();
        req = 2'b00;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_busy: busy=%b want 1", busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || gnt !== 2'b00 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async_ctl: busy=%b gnt=%b rvalid=%b want 0", busy, gnt, rvalid);
        end
        n_checks++;
        if (mem_addr !== '0 || mem_ctrl !== '0 || mem_wd !== '0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_mem: addr=%h ctrl=%h wd=%h we=%b want 0",
                     mem_addr, mem_ctrl, mem_wd, mem_we);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (rvalid !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_rvalid[%0d]: rvalid=%b gnt=%b busy=%b want 0",
                         i, rvalid, gnt, busy);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req           = 2'b01;
        addr[AW-1:0]  = 32'h100;
        ctrl[CW-1:0]  = 4'b0101;
        wd[DW-1:0]    = 32'hDEADBEEF;
        tick();
        req = 2'b00;
        n_checks++;
        if (gnt !== 2'b01 || mem_we !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_gnt: gnt=%b we=%b busy=%b want 01/1/1", gnt, mem_we, busy);
        end
        n_checks++;
        if (mem_addr !== 32'h100 || mem_wd !== 32'hDEADBEEF || mem_ctrl !== 4'b0101) begin
            n_fail++;
            $display("FAIL write_bus: addr=%h wd=%h ctrl=%b want 100/deadbeef/0101",
                     mem_addr, mem_wd, mem_ctrl);
        end
        tick();
        n_checks++;
        if (gnt !== 2'b00 || mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL write_idle: gnt=%b we=%b busy=%b addr=%h want 0",
                     gnt, mem_we, busy, mem_addr);
        end
    endtask

    task automatic test_read();
        do_reset();
        req                = 2'b10;
        addr[2*AW-1:AW]    = 32'h40;
        ctrl[2*CW-1:CW]    = 4'b0100;
        tick();                                   // N+1
        req = 2'b00;
        n_checks++;
        if (gnt !== 2'b10 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL read_gnt: gnt=%b addr=%h we=%b want 10/40/0", gnt, mem_addr, mem_we);
        end
        tick();                                   // N+2
        n_checks++;
        if (mem_addr !== 32'h40 || gnt !== 2'b00 || busy !== 1'b1 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL read_wait1: addr=%h gnt=%b busy=%b rvalid=%b", mem_addr, gnt, busy, rvalid);
        end
        tick();                                   // N+3
        mem_rd = 32'h12345678;
        n_checks++;
        if (mem_addr !== 32'h40 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL read_wait2: addr=%h rvalid=%b want 40/00", mem_addr, rvalid);
        end
        tick();                                   // N+4
        mem_rd = 32'hFFFF0000;
        n_checks++;
        if (rvalid !== 2'b10 || rdata !== 32'h12345678 || busy !== 1'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL read_rvalid: rvalid=%b rdata=%h busy=%b addr=%h want 10/12345678/0/0",
                     rvalid, rdata, busy, mem_addr);
        end
        tick();                                   // N+5
        n_checks++;
        if (rvalid !== 2'b00 || rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL read_hold: rvalid=%b rdata=%h want 00/12345678", rvalid, rdata);
        end
    endtask

    task automatic test_tie_fairness();
        logic [1:0] exp_seq [8];
        exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        ctrl = {4'b0001, 4'b0001};
        req  = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (gnt !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL tie_gnt[%0d]: gnt=%b want %b", i, gnt, exp_seq[i]);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_lock_burst();
        logic [1:0] grants [$];
        int         first0;
        do_reset();
        ctrl = {4'b0001, 4'b0001};
        lock = 2'b10;
        req  = 2'b11;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt !== 2'b00) grants.push_back(gnt);
        end
        req  = 2'b00;
        lock = 2'b00;
        first0 = -1;
        for (int i = 0; i < grants.size(); i++) begin
            if (first0 < 0 && grants[i] == 2'b01) first0 = i;
        end
        n_checks++;
        if (first0 < 0 || first0 > MAX_BURST || grants.size() < first0 + 11) begin
            n_fail++;
            $display("FAIL lock_start: first port0 grant at %0d of %0d grants", first0,
                     grants.size());
        end else begin
            // From the first port 0 grant: 0, then MAX_BURST to port 1, then 0 again, repeating.
            for (int j = 0; j < 11; j++) begin
                logic [1:0] want;
                want = ((j % (MAX_BURST + 1)) == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if (grants[first0 + j] !== want) begin
                    n_fail++;
                    $display("FAIL lock_seq[%0d]: gnt=%b want %b", j, grants[first0 + j], want);
                end
            end
        end
    endtask

    task automatic test_write_during_read();
        bit seen_rv;
        do_reset();
        req            = 2'b01;
        addr[AW-1:0]   = 32'h200;
        ctrl[CW-1:0]   = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL wdr_read_gnt: gnt=%b want 01", gnt);
        end
        req             = 2'b10;
        addr[2*AW-1:AW] = 32'h300;
        ctrl[2*CW-1:CW] = 4'b0001;
        wd[2*DW-1:DW]   = 32'hCAFE0001;
        mem_rd          = 32'hA5A5A5A5;
        seen_rv = 1'b0;
        for (int i = 0; i < 20 && !seen_rv; i++) begin
            tick();
            if (rvalid !== 2'b00) begin
                seen_rv = 1'b1;
                n_checks++;
                if (rvalid !== 2'b01 || rdata !== 32'hA5A5A5A5 || gnt !== 2'b00) begin
                    n_fail++;
                    $display("FAIL wdr_rvalid: rvalid=%b rdata=%h gnt=%b want 01/a5a5a5a5/00",
                             rvalid, rdata, gnt);
                end
            end else begin
                n_checks++;
                if (gnt !== 2'b00 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wdr_blocked[%0d]: gnt=%b we=%b want 00/0", i, gnt, mem_we);
                end
            end
        end
        n_checks++;
        if (!seen_rv) begin
            n_fail++;
            $display("FAIL wdr_timeout: rvalid=%b never pulsed, want 01", rvalid);
        end
        tick();
        req = 2'b00;
        n_checks++;
        if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wd !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL wdr_write: gnt=%b we=%b addr=%h wd=%h want 10/1/300/cafe0001",
                     gnt, mem_we, mem_addr, mem_wd);
        end
    endtask

    task automatic test_random();
        bit            pend [2];
        int            free_at, m_own, m_burst, w;
        bit            lk;
        logic [AW-1:0] a;
        logic [CW-1:0] ct;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rdata;

        for (int i = 0; i < NC; i++) begin
            e_gnt[i] = '0; e_rv[i] = '0; e_addr[i] = '0; e_ctrl[i] = '0;
            e_wd[i] = '0; e_we[i] = 1'b0; e_busy[i] = 1'b0; mrd_hist[i] = '0;
        end
        do_reset();
        pend      = '{1'b0, 1'b0};
        free_at   = 0;
        m_own     = 1;
        m_burst   = 0;
        exp_rdata = '0;

        for (int c = 0; c < NCYC; c++) begin
            // Masters: drop after their grant, occasionally raise a fresh request.
            for (int k = 0; k < 2; k++) begin
                if (pend[k] && c > 0 && e_gnt[c-1][k]) begin
                    pend[k] = 1'b0;
                    req[k]  = 1'b0;
                end
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k]            = 1'b1;
                    req[k]             = 1'b1;
                    lock[k]            = 1'($urandom_range(1));
                    addr[k*AW +: AW]   = $urandom;
                    ctrl[k*CW +: CW]   = 4'($urandom);
                    wd[k*DW +: DW]     = $urandom;
                end
            end
            mem_rd      = $urandom;
            mrd_hist[c] = mem_rd;
            if (e_rv[c] != 2'b00) exp_rdata = mrd_hist[c-1];

            @(negedge clk);
            n_checks++;
            if (gnt !== e_gnt[c]) begin
                n_fail++;
                $display("FAIL rnd_gnt @%0d: got %b want %b", c, gnt, e_gnt[c]);
            end
            n_checks++;
            if (rvalid !== e_rv[c]) begin
                n_fail++;
                $display("FAIL rnd_rvalid @%0d: got %b want %b", c, rvalid, e_rv[c]);
            end
            n_checks++;
            if (rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rnd_rdata @%0d: got %h want %h", c, rdata, exp_rdata);
            end
            n_checks++;
            if (busy !== e_busy[c]) begin
                n_fail++;
                $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, e_busy[c]);
            end
            n_checks++;
            if (mem_addr !== e_addr[c]) begin
                n_fail++;
                $display("FAIL rnd_addr @%0d: got %h want %h", c, mem_addr, e_addr[c]);
            end
            n_checks++;
            if (mem_ctrl !== e_ctrl[c]) begin
                n_fail++;
                $display("FAIL rnd_ctrl @%0d: got %b want %b", c, mem_ctrl, e_ctrl[c]);
            end
            n_checks++;
            if (mem_wd !== e_wd[c]) begin
                n_fail++;
                $display("FAIL rnd_wd @%0d: got %h want %h", c, mem_wd, e_wd[c]);
            end
            n_checks++;
            if (mem_we !== e_we[c]) begin
                n_fail++;
                $display("FAIL rnd_we @%0d: got %b want %b", c, mem_we, e_we[c]);
            end

            // Model: when free, pick a winner and lay out its transfer on the timeline.
            if (c >= free_at) begin
                w  = -1;
                lk = 1'b0;
                if (req[m_own] && lock[m_own] && m_burst < MAX_BURST - 1) begin
                    w  = m_own;
                    lk = 1'b1;
                    m_burst++;
                end else if (req == 2'b01) w = 0;
                else if (req == 2'b10) w = 1;
                else if (req == 2'b11) w = 1 - m_own;
                if (w >= 0) begin
                    if (!lk) begin
                        m_burst = 0;
                        m_own   = w;
                    end
                    a  = addr[w*AW +: AW];
                    ct = ctrl[w*CW +: CW];
                    d  = wd[w*DW +: DW];
                    e_gnt[c+1]  = 2'b01 << w;
                    e_addr[c+1] = a;
                    e_ctrl[c+1] = ct;
                    e_wd[c+1]   = d;
                    e_we[c+1]   = ct[0];
                    e_busy[c+1] = 1'b1;
                    if (ct[0]) begin
                        free_at = c + 2;
                    end else begin
                        for (int j = 2; j <= RD_LAT + 1; j++) begin
                            e_addr[c+j] = a;
                            e_ctrl[c+j] = ct;
                            e_busy[c+j] = 1'b1;
                        end
                        e_rv[c+2+RD_LAT] = 2'b01 << w;
                        free_at = c + 2 + RD_LAT;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        req  = '0;
        lock = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_tie_fairness();
        test_lock_burst();
        test_write_during_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
